// File: rtl/flasher_pkg.sv
// Shared types and segment table for the bound-flasher lamp sequencer.
// Segments run S1..S6 after a flick; IDLE is encoding 0 so seg reads 0 when stopped.
package flasher_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    S5   = 3'd5,
    S6   = 3'd6
  } seg_e;

  // Count at which each segment ends, and its stepping direction (1 = up).
  localparam int SEG_TARGET [1:6] = '{6, 0, 11, 5, 16, 0};
  localparam bit SEG_UP     [1:6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  // Boundary points where a flick kicks the bar back one segment.
  localparam int KB_LO = 6;
  localparam int KB_HI = 11;

endpackage

// File: rtl/step_timer.sv
// Step-rate divider: tick is high on every STEP_DIV-th enabled cycle.
// clr restarts the phase so the first tick lands STEP_DIV edges after a start.
module step_timer #(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            DW   = $clog2(STEP_DIV + 1);
  localparam logic [DW-1:0] LAST = DW'(STEP_DIV - 1);

  logic [DW-1:0] div_q;

  assign tick = en && (div_q == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else if (clr) begin
      div_q <= '0;
    end else if (en) begin
      div_q <= tick ? '0 : div_q + 1'b1;
    end
  end

endmodule

// File: rtl/flasher_seq_ctrl.sv
// Bound-flasher sequencer: walks the lit-lamp count through six segments on step ticks
// and drives the lamp bar as a registered thermometer code. seg exposes the FSM state.
module flasher_seq_ctrl
  import flasher_pkg::*;
#(
  parameter int NLAMP    = 16,
  parameter int STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flick,
  output logic [NLAMP-1:0] lamp,
  output logic             busy,
  output logic [2:0]       seg,
  output logic             done
);

  localparam int CW = $clog2(NLAMP + 1);

  seg_e             state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [NLAMP-1:0] lamp_q, lamp_d;
  logic             done_q, done_d;
  logic             tick;

  step_timer #(.STEP_DIV(STEP_DIV)) u_step_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == IDLE),
    .en    (state_q != IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      lamp_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lamp_q  <= lamp_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    lamp_d  = '0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (flick) state_d = S1;
      end
      S1, S2, S3, S4, S5, S6: begin
        if (tick) begin
          // Saturating step; the segment table never asks for more, so this only guards.
          if (SEG_UP[state_q]) begin
            count_d = (count_q == CW'(NLAMP)) ? count_q : count_q + 1'b1;
          end else begin
            count_d = (count_q == '0) ? count_q : count_q - 1'b1;
          end
          if (count_d == CW'(SEG_TARGET[state_q])) begin
            if (state_q == S6) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = seg_e'(state_q + 3'd1);
            end
          end else if (flick && state_q == S3 && count_d == CW'(KB_LO)) begin
            state_d = S2;
          end else if (flick && state_q == S5 && count_d == CW'(KB_HI)) begin
            state_d = S4;
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    for (int i = 0; i < NLAMP; i++) begin
      lamp_d[i] = (CW'(i) < count_d);
    end
  end

  assign lamp = lamp_q;
  assign busy = (state_q != IDLE);
  assign seg  = state_q;
  assign done = done_q;

endmodule

// File: tb/tb_flasher_seq_ctrl.sv
// Directed bench for flasher_seq_ctrl: one instance at STEP_DIV=1, one at STEP_DIV=4.
// Expected {done, seg, count} per tick comes from a hand-written segment table.
module tb_flasher_seq_ctrl;

  logic        clk;
  logic        reset_1, flick_1, busy_1, done_1;
  logic [15:0] lamp_1;
  logic [2:0]  seg_1;
  logic        reset_4, flick_4, busy_4, done_4;
  logic [15:0] lamp_4;
  logic [2:0]  seg_4;

  int n_checks = 0;
  int n_err    = 0;

  logic [8:0] exp_q[$];  // {done, seg[2:0], count[4:0]} after each tick
  int         plan [0:127];

  flasher_seq_ctrl #(.NLAMP(16), .STEP_DIV(1)) dut_1 (
    .clk(clk), .reset(reset_1), .flick(flick_1),
    .lamp(lamp_1), .busy(busy_1), .seg(seg_1), .done(done_1)
  );

  flasher_seq_ctrl #(.NLAMP(16), .STEP_DIV(4)) dut_4 (
    .clk(clk), .reset(reset_4), .flick(flick_4),
    .lamp(lamp_4), .busy(busy_4), .seg(seg_4), .done(done_4)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] therm(input int c);
    logic [15:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) if (i < c) t[i] = 1'b1;
    return t;
  endfunction

  // Lamp must always be a thermometer (no wrapped or torn count).
  always @(negedge clk) begin
    check("therm_shape_1", 32'((lamp_1 & (lamp_1 + 16'd1)) == 16'd0), 32'd1);
    check("therm_shape_4", 32'((lamp_4 & (lamp_4 + 16'd1)) == 16'd0), 32'd1);
  end

  // ---------------- expected-table builders ----------------
  task automatic seg_run(input int s, input int from, input int to, input int seg_end);
    int c;
    logic [8:0] e;
    c = from;
    while (c != to) begin
      c = (to > c) ? c + 1 : c - 1;
      e[4:0] = 5'(c);
      e[7:5] = (c == to) ? 3'(seg_end) : 3'(s);
      e[8]   = (c == to) && (seg_end == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic build_plain();
    exp_q.delete();
    seg_run(1, 0, 6, 2);   seg_run(2, 6, 0, 3);
    seg_run(3, 0, 11, 4);  seg_run(4, 11, 5, 5);
    seg_run(5, 5, 16, 6);  seg_run(6, 16, 0, 0);
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 128; i++) plan[i] = 0;
  endtask

  // ---------------- driver for the STEP_DIV=1 instance ----------------
  task automatic run_seq1(input string name, input int abort_at);
    int k;
    logic [8:0] e;
    flick_1 = 1'b1;
    @(negedge clk);
    check({name, "_start_ctl"}, {done_1, busy_1, seg_1}, {1'b0, 1'b1, 3'd1});
    check({name, "_start_lamp"}, lamp_1, 16'd0);
    k = 0;
    while (exp_q.size() > 0 && k < 128) begin
      flick_1 = plan[k][0];
      @(negedge clk);
      e = exp_q.pop_front();
      k++;
      check({name, "_ctl"}, {done_1, busy_1, seg_1}, {e[8], (e[7:5] != 3'd0), e[7:5]});
      check({name, "_lamp"}, lamp_1, therm(int'(e[4:0])));
      if (k == abort_at) break;
    end
    flick_1 = 1'b0;
  endtask

  task automatic expect_idle1(input string name);
    @(negedge clk);
    check({name, "_idle_ctl"}, {done_1, busy_1, seg_1}, 5'd0);
    check({name, "_idle_lamp"}, lamp_1, 16'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, t16, prev_c, prev_s;
    logic [8:0] e;
    reset_1 = 1'b0; flick_1 = 1'b0;
    reset_4 = 1'b0; flick_4 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ctl_1", {done_1, busy_1, seg_1}, 5'd0);
    check("reset_lamp_1", lamp_1, 16'd0);
    check("reset_ctl_4", {done_4, busy_4, seg_4}, 5'd0);
    check("reset_lamp_4", lamp_4, 16'd0);
    reset_1 = 1'b1; reset_4 = 1'b1;
    expect_idle1("release");

    // Full 56-tick run from a one-cycle flick.
    build_plain(); clear_plan();
    run_seq1("full", 0);
    expect_idle1("full");

    // Kickback at the low boundary during S3.
    exp_q.delete(); clear_plan(); plan[17] = 1;
    seg_run(1, 0, 6, 2);   seg_run(2, 6, 0, 3);
    seg_run(3, 0, 6, 2);   seg_run(2, 6, 0, 3);
    seg_run(3, 0, 11, 4);  seg_run(4, 11, 5, 5);
    seg_run(5, 5, 16, 6);  seg_run(6, 16, 0, 0);
    run_seq1("kb_lo", 0);
    expect_idle1("kb_lo");

    // Kickback at the high boundary during S5.
    exp_q.delete(); clear_plan(); plan[34] = 1;
    seg_run(1, 0, 6, 2);   seg_run(2, 6, 0, 3);
    seg_run(3, 0, 11, 4);  seg_run(4, 11, 5, 5);
    seg_run(5, 5, 11, 4);  seg_run(4, 11, 5, 5);
    seg_run(5, 5, 16, 6);  seg_run(6, 16, 0, 0);
    run_seq1("kb_hi", 0);
    expect_idle1("kb_hi");

    // Flick everywhere it must be ignored.
    build_plain(); clear_plan();
    for (int i = 0; i <= 11; i++) plan[i] = 1;
    plan[18] = 1;
    for (int i = 23; i <= 28; i++) plan[i] = 1;
    for (int i = 40; i <= 55; i++) plan[i] = 1;
    run_seq1("ignore", 0);
    expect_idle1("ignore");

    // Async reset mid-S3 at count 8.
    build_plain(); clear_plan();
    run_seq1("pre_rst", 20);
    #1 reset_1 = 1'b0; flick_1 = 1'b1;
    #1;
    check("rst_async_ctl", {done_1, busy_1, seg_1}, 5'd0);
    check("rst_async_lamp", lamp_1, 16'd0);
    exp_q.delete();
    @(negedge clk);
    check("rst_held_ctl", {done_1, busy_1, seg_1}, 5'd0);
    reset_1 = 1'b1;
    #1;
    check("rst_rel_ctl", {done_1, busy_1, seg_1}, 5'd0);
    @(negedge clk);
    check("rst_restart_ctl", {done_1, busy_1, seg_1}, {1'b0, 1'b1, 3'd1});
    flick_1 = 1'b0; reset_1 = 1'b0;
    #1 reset_1 = 1'b1;
    expect_idle1("rst_pulse");

    // STEP_DIV=4 with flick held high, dropped only at the two kickback ticks.
    build_plain();
    flick_4 = 1'b1;
    @(negedge clk);
    check("div4_start_ctl", {done_4, busy_4, seg_4}, {1'b0, 1'b1, 3'd1});
    cyc = 0; t16 = 0; prev_c = 0; prev_s = 1;
    for (int k = 1; k <= 56; k++) begin
      for (int j = 1; j <= 4; j++) begin
        flick_4 = (k == 18 || k == 35) ? 1'b0 : 1'b1;
        @(negedge clk);
        cyc++;
        if (j < 4) begin
          check("div4_hold_ctl", {done_4, busy_4, seg_4}, {1'b0, 1'b1, 3'(prev_s)});
          check("div4_hold_lamp", lamp_4, therm(prev_c));
        end else begin
          e = exp_q.pop_front();
          check("div4_tick_ctl", {done_4, busy_4, seg_4}, {e[8], (e[7:5] != 3'd0), e[7:5]});
          check("div4_tick_lamp", lamp_4, therm(int'(e[4:0])));
          prev_c = int'(e[4:0]);
          prev_s = int'(e[7:5]);
          if (prev_c == 16) t16 = cyc;
        end
      end
    end
    check("div4_fall_clks", 32'(cyc - t16), 32'd64);
    @(negedge clk);
    check("div4_restart_ctl", {done_4, busy_4, seg_4}, {1'b0, 1'b1, 3'd1});
    check("div4_restart_lamp", lamp_4, 16'd0);
    repeat (3) @(negedge clk);
    check("div4_pre_tick_lamp", lamp_4, 16'd0);
    @(negedge clk);
    check("div4_first_tick_lamp", lamp_4, 16'h0001);
    flick_4 = 1'b0;
    reset_4 = 1'b0;
    #1;
    check("div4_rst_ctl", {done_4, busy_4, seg_4}, 5'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
